// File: rtl/conv_frame_loader.sv
// ---------------------------------------------------------------------------
// conv_frame_loader
//
// Upstream stage of conv2d. Takes a raster-order pixel stream over a
// valid/ready handshake and writes every pixel into the frame RAM that
// conv2d later reads. Once a full frame is in the RAM it raises conv_start
// and holds it until conv2d shows a low-to-high transition on conv_ready.
// After that the stream is opened again for the next frame.
//
// Ports:
//   clk, rst      : clock (rising edge) and synchronous active-high reset
//   s_valid       : stream pixel valid
//   s_data        : stream pixel value
//   s_last        : end-of-frame marker, qualified by s_valid
//   s_ready       : loader can accept a pixel (only while filling)
//   mem_we        : frame RAM write enable (one cycle after each beat)
//   mem_addr      : frame RAM write address (raster pixel index)
//   mem_din       : frame RAM write data
//   conv_start    : start request to conv2d, held until completion
//   conv_ready    : conv2d ready/done level
//   frame_err     : one-cycle pulse on an early or missing s_last
//   frame_cnt     : number of completed frames, wraps at 16 bits
// ---------------------------------------------------------------------------
module conv_frame_loader #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              conv_start,
  input  logic              conv_ready,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int              N        = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pix_cnt;
  logic              ready_d;
  logic              accept;

  // The stream is open only while filling; this never looks at s_valid,
  // so the source is free to wait for ready before raising valid.
  assign s_ready = (state == ST_FILL);
  assign accept  = s_valid & s_ready;

  // Everything lives in one registered process. The write bus is the
  // accepted beat delayed by one cycle; address and data keep their last
  // value whenever no write happens. ready_d remembers conv_ready from the
  // previous cycle in every state so that only a real low-to-high change
  // seen during RUN counts as a completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FILL;
      pix_cnt    <= '0;
      ready_d    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      conv_start <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      ready_d   <= conv_ready;
      mem_we    <= accept;
      frame_err <= 1'b0;

      if (accept) begin
        mem_addr <= pix_cnt;
        mem_din  <= s_data;
      end

      case (state)
        ST_FILL: begin
          if (accept) begin
            if (pix_cnt == LAST_IDX) begin
              // Frame is complete even when s_last is missing; the
              // missing marker is only reported.
              state     <= ST_ARM;
              pix_cnt   <= '0;
              frame_err <= ~s_last;
            end else if (s_last) begin
              // Early end: drop the partial frame and start over at 0.
              pix_cnt   <= '0;
              frame_err <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + ADDR_W'(1);
            end
          end
        end

        ST_ARM: begin
          // The final pixel write is on the bus this cycle, so conv2d is
          // only started once it has landed in the RAM.
          state      <= ST_RUN;
          conv_start <= 1'b1;
        end

        ST_RUN: begin
          if (conv_ready && !ready_d) begin
            state      <= ST_FILL;
            conv_start <= 1'b0;
            frame_cnt  <= frame_cnt + 16'd1;
          end
        end

        default: begin
          state      <= ST_FILL;
          conv_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_conv_frame_loader
//
// Self-checking bench for conv_frame_loader (5x5 frame). A per-cycle
// driver applies stimulus and advances a behavioural model of the loader's
// observable contract; expected RAM writes and framing-error pulses are
// queued with the cycle in which they must appear, and a monitor on the
// falling edge pops and compares them whenever the DUT presents one.
// ---------------------------------------------------------------------------
module tb_conv_frame_loader;

  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 17;
  localparam int N      = IMG_W * IMG_H;

  // Phases of the loader as seen from outside.
  localparam int PH_FILL = 0;
  localparam int PH_ARM  = 1;
  localparam int PH_RUN  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              conv_start;
  logic              conv_ready;
  logic              frame_err;
  logic [15:0]       frame_cnt;

  conv_frame_loader #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .conv_start(conv_start),
    .conv_ready(conv_ready),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Cycle index: value k holds from the k-th rising edge to the next one.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_err[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int                m_phase;
  int                m_idx;
  logic [15:0]       m_cnt;
  logic              m_prev_cr;
  logic [ADDR_W-1:0] m_last_addr;
  logic [DATA_W-1:0] m_last_din;
  logic              mon_en = 1'b0;
  wr_t               mon_e;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Drives one cycle of inputs, checks the level outputs the model
  // predicts for the current cycle, then advances the model across the
  // coming rising edge.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                               input logic l, input logic cr);
    s_valid    = v;
    s_data     = d;
    s_last     = l;
    conv_ready = cr;
    #1;
    checkOutput("s_ready",    32'(s_ready),    32'(m_phase == PH_FILL));
    checkOutput("conv_start", 32'(conv_start), 32'(m_phase == PH_RUN));
    checkOutput("frame_cnt",  32'(frame_cnt),  32'(m_cnt));

    case (m_phase)
      PH_FILL: begin
        if (v) begin
          exp_wr.push_back('{cyc: cyc + 1, addr: ADDR_W'(m_idx), data: d});
          if (m_idx == N - 1) begin
            if (!l) exp_err.push_back(cyc + 1);
            m_idx   = 0;
            m_phase = PH_ARM;
          end else if (l) begin
            exp_err.push_back(cyc + 1);
            m_idx = 0;
          end else begin
            m_idx++;
          end
        end
      end
      PH_ARM: m_phase = PH_RUN;
      default: begin
        if (cr && !m_prev_cr) begin
          m_phase = PH_FILL;
          m_cnt   = m_cnt + 16'd1;
        end
      end
    endcase
    m_prev_cr = cr;

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic cr);
    applyStimulus(1'b0, '0, 1'b0, cr);
  endtask

  // One-cycle synchronous reset, then every output must be at its reset value.
  task automatic doReset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    m_phase     = PH_FILL;
    m_idx       = 0;
    m_cnt       = '0;
    m_prev_cr   = 1'b0;
    m_last_addr = '0;
    m_last_din  = '0;
    checkOutput("rst_mem_we",     32'(mem_we),     32'd0);
    checkOutput("rst_mem_addr",   32'(mem_addr),   32'd0);
    checkOutput("rst_mem_din",    32'(mem_din),    32'd0);
    checkOutput("rst_conv_start", 32'(conv_start), 32'd0);
    checkOutput("rst_frame_err",  32'(frame_err),  32'd0);
    checkOutput("rst_frame_cnt",  32'(frame_cnt),  32'd0);
    checkOutput("rst_s_ready",    32'(s_ready),    32'd1);
  endtask

  // Back-to-back beats; last_at < 0 means s_last is never set.
  task automatic sendBeats(input int n, input int last_at, input logic seq, input logic cr);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, seq ? DATA_W'(i + 1) : DATA_W'($urandom), (i == last_at), cr);
  endtask

  // conv_ready high 5 cycles, low 3, then high: only the final rise completes.
  task automatic completeRun();
    repeat (5) idle(1'b1);
    repeat (3) idle(1'b0);
    repeat (2) idle(1'b1);
    idle(1'b0);
  endtask

  // Monitor: compares every write and error pulse against the scoreboard,
  // and checks that the write bus holds its value between writes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we === 1'b1) begin
        if (exp_wr.size() == 0) begin
          checkOutput("unexpected_write", 32'd1, 32'd0);
        end else begin
          mon_e = exp_wr.pop_front();
          checkOutput("write_cycle", 32'(cyc),      32'(mon_e.cyc));
          checkOutput("write_addr",  32'(mem_addr), 32'(mon_e.addr));
          checkOutput("write_data",  32'(mem_din),  32'(mon_e.data));
          m_last_addr = mon_e.addr;
          m_last_din  = mon_e.data;
        end
      end else begin
        checkOutput("mem_we_low",     32'(mem_we),   32'd0);
        checkOutput("hold_mem_addr",  32'(mem_addr), 32'(m_last_addr));
        checkOutput("hold_mem_din",   32'(mem_din),  32'(m_last_din));
      end
      if (frame_err === 1'b1) begin
        if (exp_err.size() == 0) checkOutput("unexpected_frame_err", 32'd1, 32'd0);
        else checkOutput("frame_err_cycle", 32'(cyc), 32'(exp_err.pop_front()));
      end
    end
  end

  initial begin
    int acc;
    int k;
    logic v;
    conv_ready = 1'b0;
    doReset();
    mon_en = 1'b1;

    $display("[TB] nominal frame and completion handshake");
    sendBeats(N, N - 1, 1'b1, 1'b0);
    completeRun();

    $display("[TB] early last then full frame");
    sendBeats(10, 9, 1'b0, 1'b0);
    repeat (2) idle(1'b0);
    sendBeats(N, N - 1, 1'b0, 1'b0);
    completeRun();

    $display("[TB] missing last");
    sendBeats(N, -1, 1'b0, 1'b1);
    completeRun();

    $display("[TB] bursty source with valid held during run");
    acc = 0;
    k   = 0;
    while (acc < N) begin
      v = ((k % 4) == 0) || ((k % 4) == 3);
      if (v) acc++;
      applyStimulus(v, DATA_W'($urandom), v && (acc == N), 1'b0);
      k++;
    end
    repeat (4) applyStimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    completeRun();

    $display("[TB] reset mid-fill");
    sendBeats(12, -1, 1'b0, 1'b0);
    doReset();
    sendBeats(N, N - 1, 1'b0, 1'b0);
    completeRun();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), DATA_W'($urandom),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0));

    repeat (3) idle(1'b0);
    checkOutput("write_queue_drained", 32'(exp_wr.size()),  32'd0);
    checkOutput("err_queue_drained",   32'(exp_err.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
